// File: rtl/block_stacker_pkg.sv
// Shared types and widths for the block-stacker slider datapath.
package block_stacker_pkg;

  localparam int unsigned X_WIDTH     = 9;
  localparam int unsigned SIZE_WIDTH  = 4;
  localparam int unsigned LEVEL_WIDTH = 4;
  localparam int unsigned CNT_WIDTH   = 20;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    MOVE,
    CHECK,
    TRIM,
    PLACE,
    OVER,
    WIN
  } state_t;

  typedef struct packed {
    logic [X_WIDTH-1:0]    start_px;
    logic [X_WIDTH-1:0]    end_px;
    logic [SIZE_WIDTH-1:0] size;
  } blk_t;

  // Pixel width of a block of 'size' units; max 15*UNIT_PX stays inside X_WIDTH.
  function automatic logic [X_WIDTH-1:0] blk_width(input logic [SIZE_WIDTH-1:0] size,
                                                   input logic [X_WIDTH-1:0]    unit_px);
    blk_width = X_WIDTH'(size) * unit_px;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running move-step timer: one-cycle tick_c every 'period' cycles while not cleared.
module step_timer
  import block_stacker_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] period,
  output logic                 tick_c
);

  logic [CNT_WIDTH-1:0] count_q;

  assign tick_c = !clear && (count_q == CNT_WIDTH'(period - CNT_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count_q <= '0;
    end else if (tick_c) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/block_slider.sv
// Moving-block producer for the stacking game: slides, stops, trims to overlap, advances levels.
// Build option: define SPEEDUP_EN to shorten the step period as the level rises.
module block_slider
  import block_stacker_pkg::*;
#(
  parameter logic [X_WIDTH-1:0]     X_MAX       = 9'd319,
  parameter logic [X_WIDTH-1:0]     UNIT_PX     = 9'd10,
  parameter logic [SIZE_WIDTH-1:0]  INIT_SIZE   = 4'd6,
  parameter logic [CNT_WIDTH-1:0]   STEP_CYCLES = 20'd833333,
  parameter logic [LEVEL_WIDTH-1:0] MAX_LEVEL   = 4'd12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop_btn,
  output logic [X_WIDTH-1:0]     curr_block_start,
  output logic [X_WIDTH-1:0]     curr_block_end,
  output logic [SIZE_WIDTH-1:0]  curr_block_size,
  output logic [X_WIDTH-1:0]     prev_block_start,
  output logic [X_WIDTH-1:0]     prev_block_end,
  output logic [SIZE_WIDTH-1:0]  prev_block_size,
  output logic                   stop_true,
  output logic                   place_valid,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   game_over,
  output logic                   win
);

  state_t                 state_q, state_d;
  blk_t                   curr_q, curr_d;
  blk_t                   prev_q, prev_d;
  logic                   dir_left_q, dir_left_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   game_over_q, game_over_d;
  logic                   win_q, win_d;
  logic                   stop_true_q, stop_true_d;
  logic                   place_valid_q, place_valid_d;
  logic [X_WIDTH-1:0]     lo_q, lo_d;
  logic [X_WIDTH-1:0]     rem_q, rem_d;
  logic [SIZE_WIDTH-1:0]  n_q, n_d;

  logic [CNT_WIDTH-1:0]   period_c;
  logic                   tick_c;
  logic [X_WIDTH-1:0]     ov_lo_c, ov_hi_c;
  logic                   prev_none_c;

`ifdef SPEEDUP_EN
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  assign period_c = period_q;
`else
  assign period_c = STEP_CYCLES;
`endif

  step_timer u_step_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q != MOVE),
    .period (period_c),
    .tick_c (tick_c)
  );

  // Overlap window against the top of the stack; an all-zero prev means empty stack.
  assign ov_lo_c     = (curr_q.start_px > prev_q.start_px) ? curr_q.start_px : prev_q.start_px;
  assign ov_hi_c     = (curr_q.end_px < prev_q.end_px) ? curr_q.end_px : prev_q.end_px;
  assign prev_none_c = (prev_q.start_px == '0) && (prev_q.end_px == '0);

  always_comb begin
    state_d     = state_q;
    curr_d      = curr_q;
    prev_d      = prev_q;
    dir_left_d  = dir_left_q;
    level_d     = level_q;
    game_over_d = game_over_q;
    win_d       = win_q;
    lo_d        = lo_q;
    rem_d       = rem_q;
    n_d         = n_q;
`ifdef SPEEDUP_EN
    period_d    = period_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) state_d = SPAWN;
      end

      SPAWN: begin
        curr_d.start_px = '0;
        curr_d.size     = (level_q == '0) ? INIT_SIZE : prev_q.size;
        curr_d.end_px   = blk_width(curr_d.size, UNIT_PX) - X_WIDTH'(1);
        dir_left_d      = 1'b0;
`ifdef SPEEDUP_EN
        period_d = STEP_CYCLES - CNT_WIDTH'(level_q) * (STEP_CYCLES >> 4);
`endif
        state_d = MOVE;
      end

      MOVE: begin
        // A stop on the tick cycle drops that step so the block freezes where it was seen.
        if (stop_btn) begin
          state_d = CHECK;
        end else if (tick_c) begin
          if (!dir_left_q) begin
            if (curr_q.end_px == X_MAX) begin
              dir_left_d      = 1'b1;
              curr_d.start_px = curr_q.start_px - X_WIDTH'(1);
            end else begin
              curr_d.start_px = curr_q.start_px + X_WIDTH'(1);
            end
          end else if (curr_q.start_px == '0) begin
            dir_left_d      = 1'b0;
            curr_d.start_px = curr_q.start_px + X_WIDTH'(1);
          end else begin
            curr_d.start_px = curr_q.start_px - X_WIDTH'(1);
          end
          curr_d.end_px = curr_d.start_px + blk_width(curr_q.size, UNIT_PX) - X_WIDTH'(1);
        end
      end

      CHECK: begin
        n_d = '0;
        if (prev_none_c) begin
          lo_d    = curr_q.start_px;
          rem_d   = blk_width(curr_q.size, UNIT_PX);
          state_d = TRIM;
        end else if (ov_lo_c > ov_hi_c) begin
          game_over_d = 1'b1;
          state_d     = OVER;
        end else begin
          lo_d    = ov_lo_c;
          rem_d   = ov_hi_c - ov_lo_c + X_WIDTH'(1);
          state_d = TRIM;
        end
      end

      TRIM: begin
        // Divide overlap by UNIT_PX, one subtraction per cycle.
        if (rem_q >= UNIT_PX) begin
          rem_d = rem_q - UNIT_PX;
          n_d   = n_q + SIZE_WIDTH'(1);
        end else if (n_q == '0) begin
          game_over_d = 1'b1;
          state_d     = OVER;
        end else begin
          prev_d.start_px = lo_q;
          prev_d.end_px   = lo_q + blk_width(n_q, UNIT_PX) - X_WIDTH'(1);
          prev_d.size     = n_q;
          level_d         = level_q + LEVEL_WIDTH'(1);
          state_d         = PLACE;
        end
      end

      PLACE: begin
        if (level_q == MAX_LEVEL) begin
          win_d   = 1'b1;
          state_d = WIN;
        end else begin
          state_d = SPAWN;
        end
      end

      OVER, WIN: begin
        if (start) begin
          prev_d      = '0;
          level_d     = '0;
          game_over_d = 1'b0;
          win_d       = 1'b0;
          state_d     = SPAWN;
        end
      end

      default: state_d = IDLE;
    endcase

    stop_true_d   = (state_d == CHECK);
    place_valid_d = (state_d == PLACE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      curr_q        <= '0;
      prev_q        <= '0;
      dir_left_q    <= 1'b0;
      level_q       <= '0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
      stop_true_q   <= 1'b0;
      place_valid_q <= 1'b0;
      lo_q          <= '0;
      rem_q         <= '0;
      n_q           <= '0;
`ifdef SPEEDUP_EN
      period_q      <= STEP_CYCLES;
`endif
    end else begin
      state_q       <= state_d;
      curr_q        <= curr_d;
      prev_q        <= prev_d;
      dir_left_q    <= dir_left_d;
      level_q       <= level_d;
      game_over_q   <= game_over_d;
      win_q         <= win_d;
      stop_true_q   <= stop_true_d;
      place_valid_q <= place_valid_d;
      lo_q          <= lo_d;
      rem_q         <= rem_d;
      n_q           <= n_d;
`ifdef SPEEDUP_EN
      period_q      <= period_d;
`endif
    end
  end

  assign curr_block_start = curr_q.start_px;
  assign curr_block_end   = curr_q.end_px;
  assign curr_block_size  = curr_q.size;
  assign prev_block_start = prev_q.start_px;
  assign prev_block_end   = prev_q.end_px;
  assign prev_block_size  = prev_q.size;
  assign stop_true        = stop_true_q;
  assign place_valid      = place_valid_q;
  assign level            = level_q;
  assign game_over        = game_over_q;
  assign win              = win_q;

endmodule

// File: tb/tb_block_slider.sv
// Self-checking bench for block_slider with a short step period and a placement scoreboard.
module tb_block_slider;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       stop_btn = 1'b0;
  logic [8:0] curr_block_start, curr_block_end, prev_block_start, prev_block_end;
  logic [3:0] curr_block_size, prev_block_size, level;
  logic       stop_true, place_valid, game_over, win;

  typedef struct packed {
    logic       over;
    logic [8:0] s;
    logic [8:0] e;
    logic [3:0] sz;
    logic [3:0] lvl;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_ps, m_pe, m_psz, m_lvl, m_csz;

  block_slider #(.STEP_CYCLES(20'd4)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .stop_btn         (stop_btn),
    .curr_block_start (curr_block_start),
    .curr_block_end   (curr_block_end),
    .curr_block_size  (curr_block_size),
    .prev_block_start (prev_block_start),
    .prev_block_end   (prev_block_end),
    .prev_block_size  (prev_block_size),
    .stop_true        (stop_true),
    .place_valid      (place_valid),
    .level            (level),
    .game_over        (game_over),
    .win              (win)
  );

  always #5 clk = ~clk;

  // Expected outcome of stopping the current block at pixel cs.
  function automatic res_t predict(input int cs);
    int cw, ce, lo, hi, ov, n;
    res_t r;
    cw = m_csz * 10;
    ce = cs + cw - 1;
    r = {1'b1, 9'(m_ps), 9'(m_pe), 4'(m_psz), 4'(m_lvl)};
    if (m_ps == 0 && m_pe == 0) begin
      lo = cs;
      ov = cw;
    end else begin
      lo = (cs > m_ps) ? cs : m_ps;
      hi = (ce < m_pe) ? ce : m_pe;
      ov = (lo > hi) ? 0 : hi - lo + 1;
    end
    n = ov / 10;
    if (n > 0) r = {1'b0, 9'(lo), 9'(lo + n * 10 - 1), 4'(n), 4'(m_lvl + 1)};
    return r;
  endfunction

  task automatic apply_model(input res_t r);
    if (!r.over) begin
      m_ps = int'(r.s); m_pe = int'(r.e); m_psz = int'(r.sz);
      m_csz = int'(r.sz); m_lvl = int'(r.lvl);
    end
  endtask

  task automatic new_game();
    m_ps = 0; m_pe = 0; m_psz = 0; m_lvl = 0; m_csz = 6;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for a fresh spawn, stop at 'target', and capture the outcome.
  task automatic stop_at(input int target, output res_t got, output int st_cycles,
                         output int pv_cycles);
    int n;
    got = '1;
    st_cycles = 0;
    pv_cycles = 0;
    n = 0;
    while (curr_block_start != 9'd0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (curr_block_start != 9'(target) && n < 5000) begin @(negedge clk); n++; end
    if (curr_block_start != 9'(target)) return;
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    n = 0;
    while (!place_valid && !game_over && n < 300) begin
      st_cycles += int'(stop_true);
      @(negedge clk);
      n++;
    end
    if (place_valid) begin
      got = {1'b0, prev_block_start, prev_block_end, prev_block_size, level};
      pv_cycles = 1;
      @(negedge clk);
      pv_cycles += int'(place_valid);
    end else if (game_over) begin
      got = {1'b1, prev_block_start, prev_block_end, prev_block_size, level};
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({curr_block_start, curr_block_end, curr_block_size, prev_block_start, prev_block_end,
         prev_block_size, stop_true, place_valid, level, game_over, win} !== 52'd0) begin
      failures++;
      $display("FAIL reset_outputs got curr=%0d..%0d lvl=%0d go=%b win=%b required all zero",
               curr_block_start, curr_block_end, level, game_over, win);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_move();
    pulse_start();
    repeat (40) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({curr_block_start, curr_block_end, curr_block_size, prev_block_start, prev_block_end,
         prev_block_size, stop_true, place_valid, level, game_over, win} !== 52'd0) begin
      failures++;
      $display("FAIL reset_mid_move got curr=%0d..%0d size=%0d required all zero",
               curr_block_start, curr_block_end, curr_block_size);
    end
    resetn = 1'b1;
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (curr_block_start !== 9'd0 || stop_true !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got start=%0d stop_true=%b required 0 0",
               curr_block_start, stop_true);
    end
    pulse_start();
    new_game();
    @(negedge clk);
    checks++;
    if ({curr_block_start, curr_block_end, curr_block_size} !== {9'd0, 9'd59, 4'd6}) begin
      failures++;
      $display("FAIL spawn_after_reset got %0d..%0d size %0d required 0..59 size 6",
               curr_block_start, curr_block_end, curr_block_size);
    end
  endtask

  task automatic test_place();
    res_t got, e;
    int st, pv;
    int targets[3] = '{100, 130, 200};
    foreach (targets[i]) begin
      exp_q.push_back(predict(targets[i]));
      stop_at(targets[i], got, st, pv);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL place_%0d got=%h required=%h", targets[i], got, e);
      end
      checks++;
      if (st != 1 || (!e.over && pv != 1)) begin
        failures++;
        $display("FAIL pulses_%0d got stop_true=%0d place_valid=%0d cycles required 1 1",
                 targets[i], st, pv);
      end
      apply_model(e);
    end
  endtask

  task automatic test_no_overlap();
    res_t got, e;
    int st, pv;
    int targets[2] = '{100, 165};
    pulse_start();
    new_game();
    foreach (targets[i]) begin
      exp_q.push_back(predict(targets[i]));
      stop_at(targets[i], got, st, pv);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL no_overlap_%0d got=%h required=%h", targets[i], got, e);
      end
      apply_model(e);
    end
  endtask

  task automatic test_trim_zero();
    res_t got, e;
    int st, pv;
    int targets[5] = '{100, 135, 155, 100, 155};
    pulse_start();
    new_game();
    foreach (targets[i]) begin
      if (i == 3) begin
        pulse_start();
        new_game();
      end
      exp_q.push_back(predict(targets[i]));
      stop_at(targets[i], got, st, pv);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL trim_%0d_%0d got=%h required=%h", i, targets[i], got, e);
      end
      apply_model(e);
      if (i == 1) begin
        pulse_start();
        repeat (3) @(negedge clk);
        checks++;
        if (curr_block_size !== 4'd2 || level !== 4'd2) begin
          failures++;
          $display("FAIL start_ignored got size=%0d level=%0d required 2 2",
                   curr_block_size, level);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [8:0] frozen, last_s, last_e;
    int phase, n;
    frozen = curr_block_start;
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (game_over !== 1'b1 || curr_block_start !== frozen) begin
      failures++;
      $display("FAIL stop_in_over got go=%b start=%0d required 1 %0d",
               game_over, curr_block_start, frozen);
    end
    pulse_start();
    new_game();
    n = 0;
    while (curr_block_start != 9'd0 && n < 100) begin @(negedge clk); n++; end
    phase = 0;
    last_s = curr_block_start;
    last_e = curr_block_end;
    n = 0;
    while (phase < 2 && n < 4000) begin
      @(negedge clk);
      n++;
      if (curr_block_start != last_s) begin
        if (phase == 0 && last_e == 9'd319) begin
          checks++;
          if (curr_block_start !== 9'd259 || curr_block_end !== 9'd318) begin
            failures++;
            $display("FAIL right_bounce got %0d..%0d required 259..318",
                     curr_block_start, curr_block_end);
          end
          phase = 1;
        end else if (phase == 1 && last_s == 9'd0) begin
          checks++;
          if (curr_block_start !== 9'd1 || curr_block_end !== 9'd60) begin
            failures++;
            $display("FAIL left_bounce got %0d..%0d required 1..60",
                     curr_block_start, curr_block_end);
          end
          phase = 2;
        end
        last_s = curr_block_start;
        last_e = curr_block_end;
      end
    end
    if (phase < 2) begin
      checks++;
      failures++;
      $display("FAIL sweep_timeout got phase=%0d required 2", phase);
      return;
    end
    // A step just landed; the next one fires on the fourth rising edge from here.
    repeat (3) @(negedge clk);
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    checks++;
    if (curr_block_start !== 9'd1 || stop_true !== 1'b1) begin
      failures++;
      $display("FAIL stop_on_tick got start=%0d stop_true=%b required 1 1",
               curr_block_start, stop_true);
    end
    n = 0;
    while (!place_valid && !game_over && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic test_win();
    res_t got, e;
    int st, pv;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    pulse_start();
    new_game();
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(predict(10));
      stop_at(10, got, st, pv);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL win_stop_%0d got=%h required=%h", i, got, e);
      end
      apply_model(e);
    end
    @(negedge clk);
    checks++;
    if ({win, game_over, level} !== {1'b1, 1'b0, 4'd12}) begin
      failures++;
      $display("FAIL win_flags got win=%b go=%b level=%0d required 1 0 12",
               win, game_over, level);
    end
    pulse_start();
    @(negedge clk);
    checks++;
    if ({level, prev_block_start, prev_block_end, curr_block_start, curr_block_end,
         curr_block_size, win} !== {4'd0, 9'd0, 9'd0, 9'd0, 9'd59, 4'd6, 1'b0}) begin
      failures++;
      $display("FAIL restart_after_win got lvl=%0d prev=%0d/%0d curr=%0d..%0d size=%0d win=%b required 0 0/0 0..59 6 0",
               level, prev_block_start, prev_block_end, curr_block_start, curr_block_end,
               curr_block_size, win);
    end
  endtask

  initial begin
    new_game();
    test_reset();
    test_reset_mid_move();
    test_place();
    test_no_overlap();
    test_trim_zero();
    test_sweep();
    test_win();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
